// File: rtl/gpio_controller_if.sv
// Bus-side strobes and address of a gpio_controller bank.
// Data stays a plain inout port so it resolves as an ordinary tristate net.
interface gpio_controller_if;
  logic [63:0] address;
  logic        read;
  logic        write;

  modport master (
    output address,
    output read,
    output write
  );

  modport slave (
    input address,
    input read,
    input write
  );
endinterface

// File: rtl/gpio_controller.sv
// Memory-mapped GPIO bank: SET/CLR/TGL writes, synced input, edge IRQs.
// Define GPIO_DEBOUNCE_EN to add a per-pin debounce ahead of IN/edge logic.
module gpio_controller #(
  parameter int          WIDTH           = 64,
  parameter logic [63:0] BASE_ADDRESS    = 64'h1000_0000,
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  gpio_controller_if.slave bus,
  inout  wire [WIDTH-1:0]  pins,
  inout  wire [63:0]       data,
  output logic             irq
);

`ifdef GPIO_DEBOUNCE_EN
  localparam int DB_ON = 1;
`else
  localparam int DB_ON = 0;
`endif
  // Blank edges until the input path has flushed its reset zeros.
  localparam int BLANK = SYNC_STAGES + 1 + DB_ON * DEBOUNCE_CYCLES;
  localparam int BW    = $clog2(BLANK + 1);

  typedef enum logic [3:0] {
    R_PORT, R_DIR, R_IN, R_SET, R_CLR,
    R_TGL, R_IE, R_RISE, R_FALL, R_ISR, R_NONE
  } reg_e;

  reg_e             sel;
  logic [WIDTH-1:0] port_q, dir_q, ie_q;
  logic [WIDTH-1:0] rise_q, fall_q, isr_q;
  logic [WIDTH-1:0] port_d, dir_d, ie_d;
  logic [WIDTH-1:0] rise_d, fall_d, isr_d;
  logic [WIDTH-1:0] w1c, wd, in_v, prev_q;
  logic [WIDTH-1:0] evt;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [BW-1:0]    blank_q;
  logic             arm;
  logic [63:0]      rdata;
  logic             rd_hit;

  assign wd = data[WIDTH-1:0];

  always_comb begin
    sel = R_NONE;
    unique case (1'b1)
      bus.address == BASE_ADDRESS + 64'h00: sel = R_PORT;
      bus.address == BASE_ADDRESS + 64'h08: sel = R_DIR;
      bus.address == BASE_ADDRESS + 64'h10: sel = R_IN;
      bus.address == BASE_ADDRESS + 64'h18: sel = R_SET;
      bus.address == BASE_ADDRESS + 64'h20: sel = R_CLR;
      bus.address == BASE_ADDRESS + 64'h28: sel = R_TGL;
      bus.address == BASE_ADDRESS + 64'h30: sel = R_IE;
      bus.address == BASE_ADDRESS + 64'h38: sel = R_RISE;
      bus.address == BASE_ADDRESS + 64'h40: sel = R_FALL;
      bus.address == BASE_ADDRESS + 64'h48: sel = R_ISR;
      default:                              sel = R_NONE;
    endcase
  end

  always_comb begin
    port_d = port_q;
    dir_d  = dir_q;
    ie_d   = ie_q;
    rise_d = rise_q;
    fall_d = fall_q;
    w1c    = '0;
    if (bus.write) begin
      unique case (sel)
        R_PORT:  port_d = wd;
        R_DIR:   dir_d  = wd;
        R_SET:   port_d = port_q | wd;
        R_CLR:   port_d = port_q & ~wd;
        R_TGL:   port_d = port_q ^ wd;
        R_IE:    ie_d   = wd;
        R_RISE:  rise_d = wd;
        R_FALL:  fall_d = wd;
        R_ISR:   w1c    = wd;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata  = '0;
    rd_hit = 1'b1;
    unique case (sel)
      R_PORT:  rdata[WIDTH-1:0] = port_q;
      R_DIR:   rdata[WIDTH-1:0] = dir_q;
      R_IN:    rdata[WIDTH-1:0] = in_v;
      R_IE:    rdata[WIDTH-1:0] = ie_q;
      R_RISE:  rdata[WIDTH-1:0] = rise_q;
      R_FALL:  rdata[WIDTH-1:0] = fall_q;
      R_ISR:   rdata[WIDTH-1:0] = isr_q;
      default: rd_hit = 1'b0;
    endcase
  end

  // A simultaneous write owns the cycle, so the bank stays off the bus.
  assign data = (bus.read && !bus.write && rd_hit) ? rdata : 'z;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign pins[i] = dir_q[i] ? port_q[i] : 1'bz;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pins;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  logic [7:0] db_cnt [WIDTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_v <= '0;
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_q[SYNC_STAGES-1][i] != in_v[i]) begin
          if (db_cnt[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
            in_v[i]   <= sync_q[SYNC_STAGES-1][i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 8'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end
`else
  assign in_v = sync_q[SYNC_STAGES-1];
`endif

  assign arm   = (blank_q == BW'(BLANK));
  assign evt   = arm ? ((in_v & ~prev_q & rise_q) |
                        (~in_v & prev_q & fall_q)) : '0;
  // New events win over a same-cycle clear.
  assign isr_d = (isr_q & ~w1c) | evt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      port_q  <= '0;
      dir_q   <= '0;
      ie_q    <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      isr_q   <= '0;
      prev_q  <= '0;
      blank_q <= '0;
      irq     <= 1'b0;
    end else begin
      port_q <= port_d;
      dir_q  <= dir_d;
      ie_q   <= ie_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      isr_q  <= isr_d;
      prev_q <= in_v;
      irq    <= |(isr_q & ie_q);
      if (!arm) blank_q <= blank_q + 1'b1;
    end
  end

endmodule
